// File: rtl/arbitri_bus_16bit_if.sv
// Handshake and data bundle between two bus masters and the shared-bus arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface arbitri_bus_16bit_if #(
  parameter int unsigned WIDTH = 16
);
  logic             Kerkesa0;
  logic             Kerkesa1;
  logic [WIDTH-1:0] Hyrja0;
  logic [WIDTH-1:0] Hyrja1;
  logic             Lejimi0;
  logic             Lejimi1;
  logic             S;
  logic [WIDTH-1:0] Dalja;
  logic             Valid;
  logic             Zene;

  modport master (
    output Kerkesa0, Kerkesa1, Hyrja0, Hyrja1,
    input  Lejimi0, Lejimi1, S, Dalja, Valid, Zene
  );

  modport slave (
    input  Kerkesa0, Kerkesa1, Hyrja0, Hyrja1,
    output Lejimi0, Lejimi1, S, Dalja, Valid, Zene
  );
endinterface

// File: rtl/arbitri_bus_16bit.sv
// Two-requester round-robin arbiter with a registered 2:1 bus mux onto a shared write port.
// Define ARB_HOLD_LIMIT_EN to preempt an owner after MAX_HOLD words while the other side waits.
module arbitri_bus_16bit #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic                 Clock,
  input  logic                 Reset,
  arbitri_bus_16bit_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StG0, StG1} state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             lejimi0_q, lejimi1_q, zene_q, valid_q;
  logic [WIDTH-1:0] dalja_q;
  logic             xfer;
  logic [WIDTH-1:0] xfer_word;
  logic             limit_hit;

  logic             k0, k1;
  logic [WIDTH-1:0] h0, h1;

  assign k0 = bus.Kerkesa0;
  assign k1 = bus.Kerkesa1;
  assign h0 = bus.Hyrja0;
  assign h1 = bus.Hyrja1;

`ifdef ARB_HOLD_LIMIT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign limit_hit = (cnt_q == CNT_W'(MAX_HOLD - 1));

  // Any state change is an entry into a new grant (or IDLE), which restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle || state_d != state_q) begin
      cnt_d = '0;
    end else if (xfer && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign limit_hit  = 1'b0;
  assign unused_cfg = ^{32'(MAX_HOLD), 32'(CNT_W)};
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    xfer      = 1'b0;
    xfer_word = '0;
    case (state_q)
      StIdle: begin
        if (k0 && (!k1 || !ptr_q)) begin
          state_d = StG0;
        end else if (k1) begin
          state_d = StG1;
        end
      end
      StG0: begin
        if (k0) begin
          xfer      = 1'b1;
          xfer_word = h0;
          if (k1 && limit_hit) begin
            state_d = StG1;
            ptr_d   = 1'b1;
          end
        end else begin
          state_d = k1 ? StG1 : StIdle;
          ptr_d   = 1'b1;
        end
      end
      StG1: begin
        if (k1) begin
          xfer      = 1'b1;
          xfer_word = h1;
          if (k0 && limit_hit) begin
            state_d = StG0;
            ptr_d   = 1'b0;
          end
        end else begin
          state_d = k0 ? StG0 : StIdle;
          ptr_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Grant flags are decoded from the next state so they line up with state_q without extra logic.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= StIdle;
      ptr_q     <= 1'b0;
      lejimi0_q <= 1'b0;
      lejimi1_q <= 1'b0;
      zene_q    <= 1'b0;
      valid_q   <= 1'b0;
      dalja_q   <= '0;
`ifdef ARB_HOLD_LIMIT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lejimi0_q <= (state_d == StG0);
      lejimi1_q <= (state_d == StG1);
      zene_q    <= (state_d != StIdle);
      valid_q   <= xfer;
      if (xfer) begin
        dalja_q <= xfer_word;
      end
`ifdef ARB_HOLD_LIMIT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign bus.Lejimi0 = lejimi0_q;
  assign bus.Lejimi1 = lejimi1_q;
  assign bus.S       = lejimi1_q;
  assign bus.Zene    = zene_q;
  assign bus.Valid   = valid_q;
  assign bus.Dalja   = dalja_q;

endmodule

// File: tb/tb_arbitri_bus_16bit.sv
// Scoreboard bench for arbitri_bus_16bit: expected words are queued as stimulus is driven
// and popped when Valid appears; grant/select state is checked after each relevant edge.
module tb_arbitri_bus_16bit;

`ifdef ARB_HOLD_LIMIT_EN
  localparam bit HoldEn = 1'b1;
`else
  localparam bit HoldEn = 1'b0;
`endif

  logic Clock = 1'b0;
  logic Reset;

  arbitri_bus_16bit_if #(.WIDTH(16)) bus ();

  arbitri_bus_16bit #(
    .WIDTH   (16),
    .MAX_HOLD(4),
    .CNT_W   (3)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic grants(input string tag, input logic l0, input logic l1);
    check({tag, "_lejimi0"}, 32'(bus.Lejimi0), 32'(l0));
    check({tag, "_lejimi1"}, 32'(bus.Lejimi1), 32'(l1));
    check({tag, "_s"},       32'(bus.S),       32'(l1));
    check({tag, "_zene"},    32'(bus.Zene),    32'(l0 | l1));
  endtask

  // Drive one cycle of requests/data; queue the word that should transfer this cycle.
  task automatic cyc(input logic k0, input logic k1, input logic [15:0] h0, input logic [15:0] h1,
                     input bit push, input logic [15:0] w);
    bus.Kerkesa0 = k0;
    bus.Kerkesa1 = k1;
    bus.Hyrja0   = h0;
    bus.Hyrja1   = h1;
    if (push) exp_q.push_back(w);
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    Reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.Kerkesa0 = 1'($urandom);
      bus.Kerkesa1 = 1'($urandom);
      bus.Hyrja0   = 16'($urandom);
      bus.Hyrja1   = 16'($urandom);
      @(posedge Clock);
      #1;
    end
    Reset        = 1'b0;
    bus.Kerkesa0 = 1'b0;
    bus.Kerkesa1 = 1'b0;
  endtask

  always @(negedge Clock) begin
    if (bus.Valid === 1'b1) begin
      if (exp_q.size() == 0) check("sb_extra_valid", 32'(bus.Valid), 32'd0);
      else check("sb_dalja", 32'(bus.Dalja), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with random inputs
    do_reset(2);
    grants("rst", 1'b0, 1'b0);
    check("rst_valid", 32'(bus.Valid), 32'd0);
    check("rst_dalja", 32'(bus.Dalja), 32'd0);

    // Single requester burst
    cyc(1'b1, 1'b0, 16'h00A1, 16'h0, 1'b0, 16'h0);
    grants("single_grant", 1'b1, 1'b0);
    check("single_nowd", 32'(bus.Valid), 32'd0);
    cyc(1'b1, 1'b0, 16'h00A1, 16'h0, 1'b1, 16'h00A1);
    check("single_valid", 32'(bus.Valid), 32'd1);
    cyc(1'b1, 1'b0, 16'h00A2, 16'h0, 1'b1, 16'h00A2);
    cyc(1'b1, 1'b0, 16'h00A3, 16'h0, 1'b1, 16'h00A3);
    cyc(1'b0, 1'b0, 16'h0,    16'h0, 1'b0, 16'h0);
    grants("single_rel", 1'b0, 1'b0);
    check("single_vdrop", 32'(bus.Valid), 32'd0);
    cyc(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    check("single_hold", 32'(bus.Dalja), 32'h00A3);

    // Tie from IDLE after reset, then handover without a bubble
    do_reset(1);
    cyc(1'b1, 1'b1, 16'h00B1, 16'h00C1, 1'b0, 16'h0);
    grants("tie_first", 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 16'h00B1, 16'h00C1, 1'b1, 16'h00B1);
    cyc(1'b1, 1'b1, 16'h00B2, 16'h00C1, 1'b1, 16'h00B2);
    cyc(1'b0, 1'b1, 16'h0,    16'h00C1, 1'b0, 16'h0);
    grants("tie_handover", 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 16'h0, 16'h00C1, 1'b1, 16'h00C1);
    cyc(1'b0, 1'b1, 16'h0, 16'h00C2, 1'b1, 16'h00C2);
    cyc(1'b0, 1'b0, 16'h0, 16'h0,    1'b0, 16'h0);
    grants("tie_rel", 1'b0, 1'b0);

    // Both held high: preemption every 4 words only with the hold limit
    cyc(1'b1, 1'b1, 16'hD0FF, 16'hE0FF, 1'b0, 16'h0);
    grants("hold_start", 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      logic [15:0] w0, w1;
      bit          src1;
      w0   = 16'hD000 + 16'(i);
      w1   = 16'hE000 + 16'(i);
      src1 = HoldEn && (((i / 4) % 2) == 1);
      cyc(1'b1, 1'b1, w0, w1, 1'b1, src1 ? w1 : w0);
      if (i == 3) grants("hold_switch", !HoldEn, HoldEn);
    end
    grants("hold_end", 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 16'h0, 16'hE0AA, 1'b0, 16'h0);
    grants("hold_rel", 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 16'h0, 16'hE0AA, 1'b1, 16'hE0AA);
    cyc(1'b0, 1'b0, 16'h0, 16'h0,    1'b0, 16'h0);

    // Round robin: pointer flips on exit and is honoured from IDLE
    cyc(1'b1, 1'b0, 16'h1111, 16'h0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 16'h0,    16'h0, 1'b0, 16'h0);
    grants("rr_idle", 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 16'h2222, 16'h3333, 1'b0, 16'h0);
    grants("rr_ptr", 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 16'h2222, 16'h3333, 1'b1, 16'h3333);
    cyc(1'b1, 1'b0, 16'h2222, 16'h0,    1'b0, 16'h0);
    grants("rr_back", 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 16'h2222, 16'h0, 1'b1, 16'h2222);
    cyc(1'b0, 1'b0, 16'h0,    16'h0, 1'b0, 16'h0);

    // Reset in the middle of a G1 transfer (pointer is 1 going in)
    cyc(1'b0, 1'b1, 16'h0, 16'h5A01, 1'b0, 16'h0);
    grants("mb_g1", 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 16'h0, 16'h5A01, 1'b1, 16'h5A01);
    bus.Hyrja1 = 16'h5A02;
    Reset      = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    grants("mb_reset", 1'b0, 1'b0);
    check("mb_valid", 32'(bus.Valid), 32'd0);
    check("mb_dalja", 32'(bus.Dalja), 32'd0);
    cyc(1'b1, 1'b1, 16'h6B01, 16'h5A03, 1'b0, 16'h0);
    grants("mb_ptr", 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 16'h0, 16'h5A03, 1'b0, 16'h0);
    grants("mb_k1", 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 16'h0, 16'h5A03, 1'b1, 16'h5A03);
    cyc(1'b0, 1'b0, 16'h0, 16'h0,    1'b0, 16'h0);
    cyc(1'b0, 1'b0, 16'h0, 16'h0,    1'b0, 16'h0);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
